// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the IF stage: instruction class tags, MIPS opcodes, fetch FSM states.
package if_fetch_stage_pkg;

  localparam logic [3:0] INST_TYPE_NONE = 4'd0;
  localparam logic [3:0] INST_TYPE_R    = 4'd1;
  localparam logic [3:0] INST_TYPE_I    = 4'd2;
  localparam logic [3:0] INST_TYPE_MEM  = 4'd3;
  localparam logic [3:0] INST_TYPE_BR   = 4'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [0:0] {
    StFetch,
    StKillWait
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and the memory (slave).
interface if_fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_stage_inst_classify.sv
// Combinational opcode-to-class decoder; shared by the fetch stage and trace logic.
module if_fetch_stage_inst_classify
  import if_fetch_stage_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [3:0] o_type
);

  always_comb begin
    o_type = INST_TYPE_I;
    unique case (i_opcode)
      OP_RTYPE:            o_type = INST_TYPE_R;
      OP_LW, OP_SW:        o_type = INST_TYPE_MEM;
      OP_BEQ, OP_BNE, OP_J: o_type = INST_TYPE_BR;
      default:             o_type = INST_TYPE_I;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches over a req/ack bus, and feeds decode
// through registered outputs with a one-entry hold buffer for acks that land during a stall.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cu_wpcir,
  input  logic             cu_branch,
  input  logic [31:0]      ID_new_pc,
  if_fetch_stage_if.master imem,
  output logic [31:0]      if_inst,
  output logic [31:0]      if_pc4,
  output logic [3:0]       IF_ins_type,
  output logic [NUM_W-1:0] IF_ins_number
);

  fetch_state_e     r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic [31:0]      r_kill_addr, w_kill_addr_nxt;
  logic             r_buf_valid, w_buf_valid_nxt;
  logic [31:0]      r_buf_inst, w_buf_inst_nxt;
  logic [31:0]      r_inst;
  logic [31:0]      r_pc4;
  logic [3:0]       r_type;
  logic [NUM_W-1:0] r_num;

  logic        w_req;
  logic        w_ack;
  logic        w_deliver;
  logic        w_bubble;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_del_inst;
  logic [31:0] w_del_pc4;
  logic [3:0]  w_del_type;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Reset gates the request so a late ack during/after reset can never be accepted.
  assign w_req = ~rst & ((r_state == StKillWait) | ~r_buf_valid);
  assign w_ack = w_req & imem.imem_ack;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = (r_state == StKillWait) ? r_kill_addr : r_pc;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_kill_addr_nxt = r_kill_addr;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_inst_nxt  = r_buf_inst;
    w_deliver       = 1'b0;
    w_bubble        = 1'b0;
    w_del_inst      = imem.imem_rdata;
    w_del_pc4       = w_pc_plus4;

    unique case (r_state)
      StFetch: begin
        if (cu_wpcir) begin
          if (w_ack) begin
            w_buf_valid_nxt = 1'b1;
            w_buf_inst_nxt  = imem.imem_rdata;
            w_pc_nxt        = w_pc_plus4;
          end
        end else if (cu_branch) begin
          w_bubble        = 1'b1;
          w_buf_valid_nxt = 1'b0;
          w_pc_nxt        = ID_new_pc;
          if (w_req && !imem.imem_ack) begin
            w_state_nxt     = StKillWait;
            w_kill_addr_nxt = r_pc;
          end
        end else if (r_buf_valid) begin
          // pc already advanced past the buffered word, so it equals that word's pc+4.
          w_deliver       = 1'b1;
          w_del_inst      = r_buf_inst;
          w_del_pc4       = r_pc;
          w_buf_valid_nxt = 1'b0;
        end else if (w_ack) begin
          w_deliver = 1'b1;
          w_pc_nxt  = w_pc_plus4;
        end else begin
          w_bubble = 1'b1;
        end
      end

      StKillWait: begin
        if (w_ack) begin
          w_state_nxt = StFetch;
        end
        if (!cu_wpcir) begin
          w_bubble = 1'b1;
          if (cu_branch) begin
            w_pc_nxt = ID_new_pc;
          end
        end
      end

      default: begin
        w_state_nxt = StFetch;
      end
    endcase
  end

  if_fetch_stage_inst_classify u_classify (
    .i_opcode (w_del_inst[31:26]),
    .o_type   (w_del_type)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StFetch;
      r_pc        <= RESET_PC;
      r_kill_addr <= '0;
      r_buf_valid <= 1'b0;
      r_buf_inst  <= '0;
      r_inst      <= '0;
      r_pc4       <= '0;
      r_type      <= INST_TYPE_NONE;
      r_num       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_kill_addr <= w_kill_addr_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_inst  <= w_buf_inst_nxt;
      if (w_deliver) begin
        r_inst <= w_del_inst;
        r_pc4  <= w_del_pc4;
        r_type <= w_del_type;
        r_num  <= r_num + {{(NUM_W-1){1'b0}}, 1'b1};
      end else if (w_bubble) begin
        r_inst <= '0;
        r_type <= INST_TYPE_NONE;
      end
    end
  end

  assign if_inst       = r_inst;
  assign if_pc4        = r_pc4;
  assign IF_ins_type   = r_type;
  assign IF_ins_number = r_num;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal expectations plus a
// randomized run, all checked against a transaction-level fetch model every cycle.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        cu_wpcir;
  logic        cu_branch;
  logic [31:0] ID_new_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic [3:0]  IF_ins_type;
  logic [3:0]  IF_ins_number;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NUM_W    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cu_wpcir      (cu_wpcir),
    .cu_branch     (cu_branch),
    .ID_new_pc     (ID_new_pc),
    .imem          (imem_bus),
    .if_inst       (if_inst),
    .if_pc4        (if_pc4),
    .IF_ins_type   (IF_ins_type),
    .IF_ins_number (IF_ins_number)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: architectural pc, a killed request still in flight, queued stall captures.
  logic [31:0] m_pc;
  logic        m_killing;
  logic [31:0] m_kill_addr;
  logic [63:0] m_held [$];
  logic [31:0] m_inst;
  logic [31:0] m_pc4;
  logic [3:0]  m_type;
  logic [3:0]  m_num;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h, expected %08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] cls(input logic [31:0] inst);
    case (inst[31:26])
      6'h00:               return 4'd1;
      6'h23, 6'h2B:        return 4'd3;
      6'h04, 6'h05, 6'h02: return 4'd4;
      default:             return 4'd2;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0]  ops [8];
    logic [31:0] h;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0D};
    h = a * 32'h9E37_79B1 + 32'h1234_5677;
    return {ops[a[4:2]], h[25:0]};
  endfunction

  function automatic logic exp_req();
    return !rst && (m_killing || m_held.size() == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_killing ? m_kill_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_pc      = 32'h0;
    m_killing = 1'b0;
    m_held.delete();
    m_inst    = 32'h0;
    m_pc4     = 32'h0;
    m_type    = 4'd0;
    m_num     = 4'd0;
  endtask

  task automatic deliver(input logic [31:0] inst, input logic [31:0] pc4);
    m_inst = inst;
    m_pc4  = pc4;
    m_type = cls(inst);
    m_num  = m_num + 4'd1;
  endtask

  task automatic bubble();
    m_inst = 32'h0;
    m_type = 4'd0;
  endtask

  task automatic check_all();
    chk("req", 32'(imem_bus.imem_req), 32'(exp_req()));
    if (exp_req()) chk("addr", imem_bus.imem_addr, exp_addr());
    chk("if_inst", if_inst, m_inst);
    chk("if_pc4", if_pc4, m_pc4);
    chk("type", 32'(IF_ins_type), 32'(m_type));
    chk("number", 32'(IF_ins_number), 32'(m_num));
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic w, input logic b, input logic [31:0] np, input logic a,
                      input logic [31:0] rd);
    logic        req;
    logic        acc;
    logic [63:0] ent;
    cu_wpcir            = w;
    cu_branch           = b;
    ID_new_pc           = np;
    imem_bus.imem_ack   = a;
    imem_bus.imem_rdata = rd;
    req = exp_req();
    acc = req && a;
    if (m_killing) begin
      if (acc) m_killing = 1'b0;
      if (!w) begin
        bubble();
        if (b) m_pc = np;
      end
    end else if (w) begin
      if (acc) begin
        m_held.push_back({rd, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end else if (b) begin
      bubble();
      m_held.delete();
      if (req && !a) begin
        m_killing   = 1'b1;
        m_kill_addr = m_pc;
      end
      m_pc = np;
    end else if (m_held.size() != 0) begin
      ent = m_held.pop_front();
      deliver(ent[63:32], ent[31:0]);
    end else if (acc) begin
      deliver(rd, m_pc + 32'd4);
      m_pc = m_pc + 32'd4;
    end else begin
      bubble();
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    cu_wpcir            = 1'b0;
    cu_branch           = 1'b0;
    ID_new_pc           = 32'h0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    #1;
    check_all();
  endtask

  task automatic fetch_one();
    step(1'b0, 1'b0, 32'h0, 1'b1, mem_word(exp_addr()));
  endtask

  initial begin
    logic        w;
    logic        b;
    logic        a;
    logic [31:0] np;

    // Reset defaults with ack held high.
    rst = 1'b1;
    imem_bus.imem_ack = 1'b1;
    #1;
    chk("rst_req", 32'(imem_bus.imem_req), 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_type", 32'(IF_ins_type), 32'h0);
    chk("rst_num", 32'(IF_ins_number), 32'h0);
    do_reset();
    chk("rel_req", 32'(imem_bus.imem_req), 32'h1);
    chk("rel_addr", imem_bus.imem_addr, 32'h0);

    // Zero-wait stream.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8C01_0004);
    chk("zw1_pc4", if_pc4, 32'd4);
    chk("zw1_type", 32'(IF_ins_type), 32'd3);
    chk("zw1_num", 32'(IF_ins_number), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0022_1820);
    chk("zw2_pc4", if_pc4, 32'd8);
    chk("zw2_type", 32'(IF_ins_type), 32'd1);
    chk("zw2_num", 32'(IF_ins_number), 32'd2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000_FFFF);
    chk("zw3_pc4", if_pc4, 32'd12);
    chk("zw3_type", 32'(IF_ins_type), 32'd4);
    chk("zw3_num", 32'(IF_ins_number), 32'd3);

    // 3-wait memory: bubbles keep pc4/number.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("w3_inst", if_inst, 32'h0);
      chk("w3_pc4", if_pc4, 32'd12);
      chk("w3_num", 32'(IF_ins_number), 32'd3);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h2002_0005);
    chk("w3d_pc4", if_pc4, 32'd16);
    chk("w3d_type", 32'(IF_ins_type), 32'd2);
    chk("w3d_num", 32'(IF_ins_number), 32'd4);

    // Stall with buffering.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hAC03_0008);
    chk("st1_inst", if_inst, 32'h2002_0005);
    chk("st1_req", 32'(imem_bus.imem_req), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
      chk("st_req", 32'(imem_bus.imem_req), 32'h0);
      chk("st_pc4", if_pc4, 32'd16);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    chk("strel_inst", if_inst, 32'hAC03_0008);
    chk("strel_pc4", if_pc4, 32'd20);
    chk("strel_num", 32'(IF_ins_number), 32'd5);
    chk("strel_addr", imem_bus.imem_addr, 32'd20);

    // Redirect while pc=0x10 is outstanding.
    do_reset();
    repeat (4) fetch_one();
    step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("kw_addr0", imem_bus.imem_addr, 32'h10);
    chk("kw_inst0", if_inst, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("kw_addr1", imem_bus.imem_addr, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8C00_0000);
    chk("kw_discard", if_inst, 32'h0);
    chk("kw_newaddr", imem_bus.imem_addr, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0020);
    chk("kw_pc4", if_pc4, 32'h44);
    chk("kw_inst", if_inst, 32'h0000_0020);

    // Redirect with same-cycle ack, then pc+4 wrap at the top of memory.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h2222_2222);
    chk("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000);
    chk("wrap_pc4", if_pc4, 32'h0);
    chk("wrap_next", imem_bus.imem_addr, 32'h0);

    // Counter wrap and stall-over-branch priority.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      fetch_one();
      if (i == 15) chk("num15", 32'(IF_ins_number), 32'd15);
      if (i == 16) chk("num16", 32'(IF_ins_number), 32'd0);
      if (i == 17) chk("num17", 32'(IF_ins_number), 32'd1);
    end
    step(1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    chk("prio_addr0", imem_bus.imem_addr, 32'h44);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("prio_addr1", imem_bus.imem_addr, 32'h44);
    chk("prio_req", 32'(imem_bus.imem_req), 32'h1);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) < 4) begin
        do_reset();
      end else begin
        w  = ($urandom_range(0, 99) < 25);
        b  = ($urandom_range(0, 99) < 12);
        a  = ($urandom_range(0, 99) < 55);
        np = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
        step(w, b, np, a, mem_word(exp_addr()));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; producer side of the IF→ID interface.
- Owns the PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Delivers registered `if_inst`/`if_pc4` plus type/sequence tags to the decode stage.
- Honours the decode stall (`cu_wpcir`) and branch/jump redirects (`cu_branch`, `ID_new_pc`).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_W, 4, width of the instruction sequence counter `IF_ins_number`.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- cu_wpcir  in  1  decode stall; hold PC and IF outputs
- cu_branch  in  1  redirect request from decode
- ID_new_pc  in  32  redirect target, valid with `cu_branch`
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (word aligned)
- imem_ack  in  1  response valid
- imem_rdata  in  32  fetched instruction, valid with `imem_ack`
- if_inst  out  32  instruction to decode; 0 (nop) when bubble
- if_pc4  out  32  address of `if_inst` + 4
- IF_ins_type  out  4  instruction class tag
- IF_ins_number  out  NUM_W  delivered-instruction sequence number

Behaviour:
- Clock/reset: one clock (`clk`); `rst` asynchronous, active-high.
- Reset values:
  - pc=RESET_PC
  - imem_req=0
  - if_inst=0
  - if_pc4=0
  - IF_ins_type=INST_TYPE_NONE
  - IF_ins_number=0
  - hold buffer empty
  - state=FETCH
- Reset mid-fetch: any outstanding request is abandoned. A late `imem_ack` arriving after reset while `imem_req`=0 is ignored.
- Handshake:
  - `imem_req`=1 with `imem_addr`=pc.
  - `imem_addr` stays stable until `imem_ack`.
  - `imem_ack` may arrive in the same cycle as `req` (zero-wait) or later.
  - `imem_ack` with `imem_req`=0 is ignored.
- Latency and throughput: an accepted response appears on `if_inst` on the next rising edge. Zero-wait memory gives one instruction per cycle.
- Delivery (ack, not stalled, not killed):
  - if_inst←imem_rdata
  - if_pc4←pc+4
  - IF_ins_type←decode(opcode)
  - IF_ins_number←IF_ins_number+1, wrapping 2^NUM_W−1→0
  - pc←pc+4
- Bubble: cycle with no delivery and no stall.
  - if_inst←0, IF_ins_type←INST_TYPE_NONE.
  - if_pc4 and IF_ins_number hold.
- Stall (`cu_wpcir`=1):
  - All IF outputs and pc hold.
  - An ack arriving during the stall is captured in a one-entry hold buffer, and pc advances.
  - `imem_req`=0 while the buffer is full.
  - On stall release, the buffer is delivered first, then fetching resumes.
- Redirect (`cu_branch`=1 and `cu_wpcir`=0):
  - pc←ID_new_pc.
  - Hold buffer is flushed.
  - Next cycle's outputs are a bubble.
  - The instruction currently on the outputs is not squashed here; decode squashes it.
- Priority: rst > cu_wpcir > cu_branch. `cu_branch` is ignored while `cu_wpcir`=1; control re-asserts it after the stall.
- FSM:
  - FETCH: `req`=1 unless the buffer is full.
  - FETCH→KILL_WAIT: redirect while a request is outstanding with no ack in that cycle.
  - FETCH→FETCH: redirect with ack in the same cycle; that response is discarded and the new fetch is issued the following cycle.
  - KILL_WAIT: `req`=1 and `imem_addr` held at the old address until ack. The ack response is discarded, then → FETCH with `imem_addr`=new pc.
  - A second redirect in KILL_WAIT updates the target pc only.
- Type decode (opcode = inst[31:26]):
  - 0x00 → INST_TYPE_R
  - 0x23/0x2B → INST_TYPE_MEM
  - 0x04/0x05/0x02 → INST_TYPE_BR
  - other → INST_TYPE_I
- Arithmetic: all PC math is 32-bit modulo; pc+4 wraps 0xFFFF_FFFC→0.

Decomposition:
- Shared macro/package constants: INST_TYPE_NONE=0, INST_TYPE_R=1, INST_TYPE_I=2, INST_TYPE_MEM=3, INST_TYPE_BR=4, plus opcode constants.
- One sub-module: `inst_classify` (combinational opcode→type), reused by trace logic.

Test Plan:
- Reset-default check: assert rst with imem_ack=1 → imem_req=0, if_inst=0, IF_ins_type=0, IF_ins_number=0. After release, imem_addr=0 with imem_req=1.
- Zero-wait stream: ack every cycle with rdata=0x8C010004,0x00221820,0x1000FFFF → outputs on consecutive cycles.
  - if_pc4 = 4, 8, 12.
  - types = MEM, R, BR.
  - IF_ins_number = 1, 2, 3.
- 3-wait memory: ack every 4th cycle → 3 bubbles between deliveries (if_inst=0, type NONE); if_pc4 and IF_ins_number unchanged across bubbles.
- Stall with buffering: cu_wpcir=1 for 3 cycles while ack arrives on stall cycle 1.
  - Outputs frozen; imem_req=0 on cycles 2–3.
  - On release, the buffered instruction is delivered with the next pc4.
- Redirect during wait: cu_branch=1, ID_new_pc=0x40 while pc=0x10 is outstanding.
  - imem_addr stays 0x10 until ack, and that response is discarded.
  - Then imem_addr=0x40; first delivered if_pc4=0x44.
- Counter wrap and stall priority: deliver 17 instructions → IF_ins_number wraps 15→0→1. cu_branch together with cu_wpcir=1 → pc unchanged.
